// File: rtl/jk_cmd_sequencer_if.sv
// Command handshake bundle between a command source and jk_cmd_sequencer.
// Signal names follow the sequencer's published port names.
interface jk_cmd_sequencer_if;
    logic       iCmdValid;
    logic       oCmdReady;
    logic [1:0] iCmd;
    logic [3:0] iRepeat;

    modport master (
        output iCmdValid,
        output iCmd,
        output iRepeat,
        input  oCmdReady
    );

    modport slave (
        input  iCmdValid,
        input  iCmd,
        input  iRepeat,
        output oCmdReady
    );
endinterface

// File: rtl/jk_cmd_sequencer.sv
// Queues J/K commands in a small FIFO and drives them to a downstream JK flip-flop,
// tracking the expected flip-flop state and flagging any disagreement with the returned Q.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                iClk,
    input  logic                iRst,
    jk_cmd_sequencer_if.slave   cmd,
    output logic                oJ,
    output logic                oK,
    input  logic                iQ,
    input  logic                iCheckEn,
    output logic                oQModel,
    output logic                oMismatch,
    output logic                oBusy,
    output logic [7:0]          oToggleCnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  fifo_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic        j_q, j_d;
    logic        k_q, k_d;
    logic [3:0]  rep_q, rep_d;
    logic        qmodel_q, qmodel_d;
    logic        mismatch_q, mismatch_d;
    logic [7:0]  toggle_q, toggle_d;

    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        pop_s;
    logic [5:0]  head_s;

    assign full_s        = (count_q == (AW+1)'(DEPTH));
    assign empty_s       = (count_q == {(AW+1){1'b0}});
    assign push_s        = cmd.iCmdValid & ~full_s;
    assign head_s        = fifo_q[rd_ptr_q];
    assign cmd.oCmdReady = ~full_s;

    assign oJ         = j_q;
    assign oK         = k_q;
    assign oQModel    = qmodel_q;
    assign oMismatch  = mismatch_q;
    assign oBusy      = (state_q == ST_DRIVE);
    assign oToggleCnt = toggle_q;

    // Sequencer FSM: pops the FIFO head into the J/K drive registers and counts repeats.
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        k_d     = k_q;
        rep_d   = rep_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_d = ST_DRIVE;
                    j_d     = head_s[5];
                    k_d     = head_s[4];
                    rep_d   = head_s[3:0];
                end else begin
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (rep_q != 4'd0) begin
                    rep_d = rep_q - 4'd1;
                end else if (!empty_s) begin
                    // Back-to-back: next command starts without an idle gap.
                    pop_s = 1'b1;
                    j_d   = head_s[5];
                    k_d   = head_s[4];
                    rep_d = head_s[3:0];
                end else begin
                    state_d = ST_IDLE;
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                j_d     = 1'b0;
                k_d     = 1'b0;
                rep_d   = 4'd0;
            end
        endcase
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Expected flip-flop state, sticky compare flag and toggle-cycle counter.
    always_comb begin
        qmodel_d = qmodel_q;
        case ({j_q, k_q})
            2'b10:   qmodel_d = 1'b1;
            2'b01:   qmodel_d = 1'b0;
            2'b11:   qmodel_d = ~qmodel_q;
            default: qmodel_d = qmodel_q;
        endcase
        mismatch_d = mismatch_q | (iCheckEn & (iQ != qmodel_q));
        if (j_q && k_q) begin
            toggle_d = toggle_q + 8'd1;
        end else begin
            toggle_d = toggle_q;
        end
    end

    // State registers; reset wins over push, pop and compare.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {(AW+1){1'b0}};
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            rep_q      <= 4'd0;
            qmodel_q   <= 1'b0;
            mismatch_q <= 1'b0;
            toggle_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            j_q        <= j_d;
            k_q        <= k_d;
            rep_q      <= rep_d;
            qmodel_q   <= qmodel_d;
            mismatch_q <= mismatch_d;
            toggle_q   <= toggle_d;
        end
    end

    // FIFO storage; flushing is done by clearing the pointers, so no reset here.
    always_ff @(posedge iClk) begin
        if (push_s && !iRst) begin
            fifo_q[wr_ptr_q] <= {cmd.iCmd, cmd.iRepeat};
        end
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer with a behavioural JK flip-flop closing the iQ loop.
module tb_jk_cmd_sequencer;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       oJ, oK, iQ, iCheckEn, oQModel, oMismatch, oBusy;
    logic [7:0] oToggleCnt;
    logic       q_ff;
    logic       q_flip;
    int         n_vec  = 0;
    int         n_miss = 0;
    int         cyc    = 0;

    jk_cmd_sequencer_if cmd_if ();

    jk_cmd_sequencer #(.DEPTH(4)) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .cmd        (cmd_if.slave),
        .oJ         (oJ),
        .oK         (oK),
        .iQ         (iQ),
        .iCheckEn   (iCheckEn),
        .oQModel    (oQModel),
        .oMismatch  (oMismatch),
        .oBusy      (oBusy),
        .oToggleCnt (oToggleCnt)
    );

    always #5 iClk = ~iClk;

    // Downstream JK flip-flop driven by the sequencer outputs.
    always @(posedge iClk) begin
        if (iRst) begin
            q_ff <= 1'b0;
        end else begin
            case ({oJ, oK})
                2'b10:   q_ff <= 1'b1;
                2'b01:   q_ff <= 1'b0;
                2'b11:   q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
    end

    assign iQ = q_ff ^ q_flip;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
        cyc++;
    endtask

    task automatic set_cmd(input logic v, input logic [1:0] c, input logic [3:0] r);
        cmd_if.iCmdValid = v;
        cmd_if.iCmd      = c;
        cmd_if.iRepeat   = r;
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
    endtask

    task automatic wait_ready(output int waited);
        waited = 0;
        while (!cmd_if.oCmdReady && waited < 200) begin
            tick();
            waited++;
        end
    endtask

    task automatic tick_until(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq_cmd [6];
        int         w;
        logic       seen;

        seq_cmd[0] = 2'b10; seq_cmd[1] = 2'b01; seq_cmd[2] = 2'b10;
        seq_cmd[3] = 2'b01; seq_cmd[4] = 2'b10; seq_cmd[5] = 2'b01;
        iCheckEn = 1'b0;
        q_flip   = 1'b0;
        set_cmd(1'b0, 2'b00, 4'd0);

        // Reset state
        do_reset();
        iCheckEn = 1'b1;
        check_eq("rst_jk",     {oJ, oK}, 2'b00);
        check_eq("rst_busy",   oBusy, 1'b0);
        check_eq("rst_ready",  cmd_if.oCmdReady, 1'b1);
        check_eq("rst_toggle", oToggleCnt, 8'd0);
        check_eq("rst_mism",   oMismatch, 1'b0);
        check_eq("rst_qmodel", oQModel, 1'b0);

        // Set repeat 0 then reset repeat 1
        set_cmd(1'b1, 2'b10, 4'd0);
        tick();
        set_cmd(1'b1, 2'b01, 4'd1);
        tick();
        set_cmd(1'b0, 2'b00, 4'd0);
        check_eq("seq_jk0",  {oJ, oK}, 2'b10);
        check_eq("seq_busy", oBusy, 1'b1);
        tick();
        check_eq("seq_jk1", {oJ, oK}, 2'b01);
        check_eq("seq_q1",  oQModel, 1'b1);
        tick();
        check_eq("seq_jk2", {oJ, oK}, 2'b01);
        check_eq("seq_q2",  oQModel, 1'b0);
        tick();
        check_eq("seq_jk3",   {oJ, oK}, 2'b00);
        check_eq("seq_idle",  oBusy, 1'b0);
        check_eq("seq_q3",    oQModel, 1'b0);

        // Toggle repeat 3 with flip-flop in the loop
        set_cmd(1'b1, 2'b11, 4'd3);
        tick();
        set_cmd(1'b0, 2'b00, 4'd0);
        tick();
        check_eq("tog_jk", {oJ, oK}, 2'b11);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_eq("tog_iq", iQ, 32'(k % 2));
        end
        check_eq("tog_cnt",  oToggleCnt, 8'd4);
        check_eq("tog_mism", oMismatch, 1'b0);
        check_eq("tog_idle", {oJ, oK}, 2'b00);

        // Fill the FIFO behind a long command; sixth entry must wait
        set_cmd(1'b1, seq_cmd[0], 4'd15);
        tick();
        set_cmd(1'b1, seq_cmd[1], 4'd15);
        tick();
        cyc = 0;
        check_eq("full_e0", {oJ, oK}, 2'b10);
        for (int i = 2; i < 5; i++) begin
            set_cmd(1'b1, seq_cmd[i], 4'd15);
            tick();
        end
        check_eq("full_ready", cmd_if.oCmdReady, 1'b0);
        set_cmd(1'b1, seq_cmd[5], 4'd15);
        wait_ready(w);
        check_eq("full_wait", w, 13);
        tick();
        set_cmd(1'b0, 2'b00, 4'd0);
        for (int k = 1; k < 6; k++) begin
            tick_until(16 * k + 8);
            check_eq("full_drain", {oJ, oK}, seq_cmd[k]);
        end
        tick_until(96);
        check_eq("full_end_jk",   {oJ, oK}, 2'b00);
        check_eq("full_end_busy", oBusy, 1'b0);

        // 300 toggle cycles wrap the counter to 44
        do_reset();
        for (int i = 0; i < 19; i++) begin
            set_cmd(1'b1, 2'b11, (i == 18) ? 4'd11 : 4'd15);
            wait_ready(w);
            tick();
        end
        set_cmd(1'b0, 2'b00, 4'd0);
        w = 0;
        while (oBusy && w < 400) begin
            tick();
            w++;
        end
        check_eq("wrap_drained", oBusy, 1'b0);
        check_eq("wrap_cnt",     oToggleCnt, 8'd44);
        check_eq("wrap_q",       oQModel, 1'b0);
        check_eq("wrap_mism",    oMismatch, 1'b0);

        // Reset mid-drive with three entries queued, push offered during reset
        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b1, 2'b10, 4'd15);
            tick();
        end
        check_eq("mid_busy_pre", oBusy, 1'b1);
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        set_cmd(1'b0, 2'b00, 4'd0);
        check_eq("mid_jk",     {oJ, oK}, 2'b00);
        check_eq("mid_busy",   oBusy, 1'b0);
        check_eq("mid_ready",  cmd_if.oCmdReady, 1'b1);
        check_eq("mid_toggle", oToggleCnt, 8'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | oJ | oK | oBusy;
        end
        check_eq("mid_nodrive", seen, 1'b0);

        // Forced Q disagreement is sticky until reset
        q_flip = 1'b1;
        tick();
        q_flip = 1'b0;
        check_eq("mism_set", oMismatch, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        check_eq("mism_hold", oMismatch, 1'b1);
        do_reset();
        check_eq("mism_clr", oMismatch, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
